// File: rtl/wb_dcache_nway.sv
// N-way set-associative write-back, write-allocate data cache with a line-wide memory port.
// Optional hit/miss counters are compiled in with WB_DCACHE_PERF_CNT_EN.
`timescale 1ns/1ps
module wb_dcache_nway #(
    parameter int WAYS      = 2,
    parameter int SETS      = 64,
    parameter int LINE_BITS = 128
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 dmem_sel_i,
    input  logic                 dcache_flush_i,
    input  logic                 req_i,
    input  logic                 w_en_i,
    input  logic [31:0]          addr_i,
    input  logic [31:0]          w_data_i,
    input  logic [3:0]           sel_byte_i,
    output logic                 ack_o,
    output logic [31:0]          r_data_o,
    output logic                 flush_done_o,
    output logic                 mem_req_o,
    output logic                 mem_w_en_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_w_data_o,
    input  logic [LINE_BITS-1:0] mem_r_data_i,
    input  logic                 mem_ack_i
`ifdef WB_DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]          hit_cnt_o,
    output logic [31:0]          miss_cnt_o
`endif
);
    localparam int OFF_W  = $clog2(LINE_BITS / 8);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = 32 - OFF_W - IDX_W;
    localparam int WSEL_W = $clog2(LINE_BITS / 32);
    localparam int WPL    = LINE_BITS / 32;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_COMPARE    = 3'd1;
    localparam logic [2:0] S_WRITEBACK  = 3'd2;
    localparam logic [2:0] S_ALLOCATE   = 3'd3;
    localparam logic [2:0] S_FLUSH_SCAN = 3'd4;
    localparam logic [2:0] S_FLUSH_WB   = 3'd5;

    logic [2:0]           state_q;
    logic [WAYS-1:0]      valid_q [SETS];
    logic [WAYS-1:0]      dirty_q [SETS];
    logic [WAY_W-1:0]     rr_q    [SETS];
    logic [TAG_W-1:0]     tag_q   [SETS][WAYS];
    logic [LINE_BITS-1:0] data_q  [SETS][WAYS];
    logic [WAY_W-1:0]     vict_q;
    logic                 flush_pend_q;
    logic [IDX_W-1:0]     scan_set_q;
    logic [WAY_W-1:0]     scan_way_q;

    logic [31:2]          req_addr_q;
    logic [31:0]          req_data_q;
    logic                 req_wen_q;
    logic [3:0]           req_sel_q;

    logic                 unused_addr_lsb;
    assign unused_addr_lsb = ^addr_i[1:0];

    logic [IDX_W-1:0]     req_idx;
    logic [TAG_W-1:0]     req_tag;
    logic [WSEL_W-1:0]    req_word;
    assign req_idx  = req_addr_q[OFF_W +: IDX_W];
    assign req_tag  = req_addr_q[31 -: TAG_W];
    assign req_word = req_addr_q[OFF_W-1:2];

    logic                 hit, inv_found, mem_fire, scan_last, vict_dirty;
    logic [WAY_W-1:0]     hit_way, inv_way, victim;
    logic [LINE_BITS-1:0] hit_line, merged_line;
    logic [31:0]          hit_word, new_word;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!hit && valid_q[req_idx][w] && tag_q[req_idx][w] == req_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!inv_found && !valid_q[req_idx][w]) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim     = inv_found ? inv_way : rr_q[req_idx];
        vict_dirty = valid_q[req_idx][victim] && dirty_q[req_idx][victim];
    end

    // Word extraction and byte-merge for the hit way.
    always_comb begin
        hit_line    = data_q[req_idx][hit_way];
        hit_word    = '0;
        new_word    = '0;
        merged_line = hit_line;
        for (int k = 0; k < WPL; k++)
            if (req_word == WSEL_W'(k)) hit_word = hit_line[k*32 +: 32];
        for (int b = 0; b < 4; b++)
            new_word[b*8 +: 8] = req_sel_q[b] ? req_data_q[b*8 +: 8] : hit_word[b*8 +: 8];
        for (int k = 0; k < WPL; k++)
            if (req_word == WSEL_W'(k)) merged_line[k*32 +: 32] = new_word;
    end

    assign ack_o     = (state_q == S_COMPARE) && hit;
    assign r_data_o  = ack_o ? hit_word : 32'h0;
    assign mem_fire  = mem_req_o && mem_ack_i;
    assign scan_last = (scan_set_q == IDX_W'(SETS - 1)) && (scan_way_q == WAY_W'(WAYS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                rr_q[s]    <= '0;
            end
            vict_q       <= '0;
            flush_pend_q <= 1'b0;
            flush_done_o <= 1'b0;
            scan_set_q   <= '0;
            scan_way_q   <= '0;
            mem_req_o    <= 1'b0;
            mem_w_en_o   <= 1'b0;
            mem_addr_o   <= '0;
            mem_w_data_o <= '0;
        end else begin
            flush_done_o <= 1'b0;
            if (dcache_flush_i && state_q != S_IDLE) flush_pend_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (flush_pend_q || dcache_flush_i) begin
                        flush_pend_q <= 1'b0;
                        scan_set_q   <= '0;
                        scan_way_q   <= '0;
                        state_q      <= S_FLUSH_SCAN;
                    end else if (req_i && dmem_sel_i) begin
                        state_q <= S_COMPARE;
                    end
                end
                S_COMPARE: begin
                    if (hit) begin
                        if (req_wen_q) dirty_q[req_idx][hit_way] <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        vict_q    <= victim;
                        mem_req_o <= 1'b1;
                        if (vict_dirty) begin
                            mem_w_en_o   <= 1'b1;
                            mem_addr_o   <= {tag_q[req_idx][victim], req_idx, OFF_W'(0)};
                            mem_w_data_o <= data_q[req_idx][victim];
                            state_q      <= S_WRITEBACK;
                        end else begin
                            mem_w_en_o <= 1'b0;
                            mem_addr_o <= {req_addr_q[31:OFF_W], OFF_W'(0)};
                            state_q    <= S_ALLOCATE;
                        end
                    end
                end
                S_WRITEBACK: begin
                    if (mem_fire) begin
                        mem_req_o                <= 1'b0;
                        mem_w_en_o               <= 1'b0;
                        valid_q[req_idx][vict_q] <= 1'b0;
                        dirty_q[req_idx][vict_q] <= 1'b0;
                        state_q                  <= S_ALLOCATE;
                    end
                end
                S_ALLOCATE: begin
                    // Coming from WRITEBACK the request is idle for one cycle and is raised here.
                    if (!mem_req_o) begin
                        mem_req_o  <= 1'b1;
                        mem_w_en_o <= 1'b0;
                        mem_addr_o <= {req_addr_q[31:OFF_W], OFF_W'(0)};
                    end else if (mem_fire) begin
                        mem_req_o                <= 1'b0;
                        valid_q[req_idx][vict_q] <= 1'b1;
                        dirty_q[req_idx][vict_q] <= 1'b0;
                        rr_q[req_idx] <= (rr_q[req_idx] == WAY_W'(WAYS - 1)) ? '0
                                         : rr_q[req_idx] + WAY_W'(1);
                        state_q <= S_COMPARE;
                    end
                end
                S_FLUSH_SCAN, S_FLUSH_WB: begin
                    if (state_q == S_FLUSH_SCAN && valid_q[scan_set_q][scan_way_q]
                        && dirty_q[scan_set_q][scan_way_q]) begin
                        mem_req_o    <= 1'b1;
                        mem_w_en_o   <= 1'b1;
                        mem_addr_o   <= {tag_q[scan_set_q][scan_way_q], scan_set_q, OFF_W'(0)};
                        mem_w_data_o <= data_q[scan_set_q][scan_way_q];
                        state_q      <= S_FLUSH_WB;
                    end else if (state_q == S_FLUSH_SCAN || mem_fire) begin
                        mem_req_o                          <= 1'b0;
                        mem_w_en_o                         <= 1'b0;
                        valid_q[scan_set_q][scan_way_q]    <= 1'b0;
                        dirty_q[scan_set_q][scan_way_q]    <= 1'b0;
                        if (scan_last) begin
                            flush_done_o <= 1'b1;
                            state_q      <= S_IDLE;
                        end else begin
                            state_q <= S_FLUSH_SCAN;
                            if (scan_way_q == WAY_W'(WAYS - 1)) begin
                                scan_way_q <= '0;
                                scan_set_q <= scan_set_q + IDX_W'(1);
                            end else begin
                                scan_way_q <= scan_way_q + WAY_W'(1);
                            end
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Request latch and line storage carry no reset; valid bits guard their contents.
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE) begin
            req_addr_q <= addr_i[31:2];
            req_data_q <= w_data_i;
            req_wen_q  <= w_en_i;
            req_sel_q  <= sel_byte_i;
        end
        if (state_q == S_COMPARE && hit && req_wen_q)
            data_q[req_idx][hit_way] <= merged_line;
        if (state_q == S_ALLOCATE && mem_fire) begin
            data_q[req_idx][vict_q] <= mem_r_data_i;
            tag_q[req_idx][vict_q]  <= req_tag;
        end
    end

`ifdef WB_DCACHE_PERF_CNT_EN
    // first_q marks the COMPARE entered straight from IDLE; refill re-entries do not count.
    logic first_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            first_q    <= 1'b0;
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else if (state_q == S_IDLE) begin
            first_q <= 1'b1;
        end else if (state_q == S_COMPARE) begin
            first_q <= 1'b0;
            if (first_q) begin
                if (hit) hit_cnt_o  <= hit_cnt_o + 32'd1;
                else     miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_wb_dcache_nway.sv
// Directed bench for wb_dcache_nway: read/line scoreboards plus a line-wide memory responder.
`timescale 1ns/1ps
module tb_wb_dcache_nway;
  localparam int LB = 128;

  logic          clk_i = 1'b0, rst_ni = 1'b0;
  logic          dmem_sel_i = 1'b1, dcache_flush_i = 1'b0, req_i = 1'b0, w_en_i = 1'b0;
  logic [31:0]   addr_i = '0, w_data_i = '0;
  logic [3:0]    sel_byte_i = '0;
  logic          ack_o, flush_done_o, mem_req_o, mem_w_en_o, mem_ack_i;
  logic [31:0]   r_data_o, mem_addr_o;
  logic [LB-1:0] mem_w_data_o, mem_r_data_i;
`ifdef WB_DCACHE_PERF_CNT_EN
  logic [31:0]   hit_cnt_o, miss_cnt_o;
`endif

  wb_dcache_nway #(.WAYS(2), .SETS(64), .LINE_BITS(LB)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .dmem_sel_i(dmem_sel_i), .dcache_flush_i(dcache_flush_i),
    .req_i(req_i), .w_en_i(w_en_i), .addr_i(addr_i), .w_data_i(w_data_i), .sel_byte_i(sel_byte_i),
    .ack_o(ack_o), .r_data_o(r_data_o), .flush_done_o(flush_done_o),
    .mem_req_o(mem_req_o), .mem_w_en_o(mem_w_en_o), .mem_addr_o(mem_addr_o),
    .mem_w_data_o(mem_w_data_o), .mem_r_data_i(mem_r_data_i), .mem_ack_i(mem_ack_i)
`ifdef WB_DCACHE_PERF_CNT_EN
    , .hit_cnt_o(hit_cnt_o), .miss_cnt_o(miss_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_assert = 0, n_fail = 0;
  int n_mem_wr = 0, n_mem_rd = 0;
  int exp_hits = 0, exp_misses = 0;

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    n_assert++;
    if (obs !== exp) begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic w; logic [31:0] a; logic [LB-1:0] d; } mem_t;
  mem_t          exp_mem[$];
  logic [31:0]   rd_q[$];
  logic [31:0]   shadow [logic [31:0]];
  logic [LB-1:0] mem_store [logic [31:0]];

  function automatic logic [31:0] pat(input logic [31:0] a);
    return a ^ 32'hC0DE_5A00;
  endfunction

  function automatic logic [LB-1:0] pat_line(input logic [31:0] a);
    logic [LB-1:0] l;
    for (int k = 0; k < LB / 32; k++) l[k*32 +: 32] = pat({a[31:4], 4'h0} + 32'(4 * k));
    return l;
  endfunction

  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    logic [31:0] key;
    key = {a[31:2], 2'b00};
    return shadow.exists(key) ? shadow[key] : pat(key);
  endfunction

  function automatic void sh_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] sel);
    logic [31:0] v;
    v = sh_rd(a);
    for (int b = 0; b < 4; b++) if (sel[b]) v[b*8 +: 8] = d[b*8 +: 8];
    shadow[{a[31:2], 2'b00}] = v;
  endfunction

  function automatic logic [LB-1:0] sh_line(input logic [31:0] a);
    logic [LB-1:0] l;
    for (int k = 0; k < LB / 32; k++) l[k*32 +: 32] = sh_rd({a[31:4], 4'h0} + 32'(4 * k));
    return l;
  endfunction

  // Memory responder: checks each new transfer against the expected queue, acks on its third cycle.
  initial begin
    int   cnt;
    mem_t e;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_r_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        cnt = 0;
        mem_ack_i = 1'b0;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0;
      end else if (mem_req_o) begin
        cnt++;
        if (cnt == 1) begin
          chk("mem_expected", exp_mem.size() > 0, 1'b1);
          if (exp_mem.size() > 0) begin
            e = exp_mem.pop_front();
            chk("mem_w_en", mem_w_en_o, e.w);
            chk("mem_addr", mem_addr_o, e.a);
            if (e.w) chk("mem_w_data", mem_w_data_o, e.d);
          end
          if (mem_w_en_o) begin
            mem_store[mem_addr_o] = mem_w_data_o;
            n_mem_wr++;
          end else begin
            mem_r_data_i = mem_store.exists(mem_addr_o) ? mem_store[mem_addr_o]
                                                         : pat_line(mem_addr_o);
            n_mem_rd++;
          end
        end
        if (cnt == 3) begin
          mem_ack_i = 1'b1;
          cnt = 0;
        end
      end
    end
  end

  task automatic push_wb(input logic [31:0] a);
    exp_mem.push_back('{1'b1, a, sh_line(a)});
  endtask

  task automatic access(input bit w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] sel, input bit miss, input string tag);
    bit got;
    int lat;
    if (miss) begin
      exp_mem.push_back('{1'b0, {a[31:4], 4'h0}, {LB{1'b0}}});
      exp_misses++;
    end else begin
      exp_hits++;
    end
    if (!w) rd_q.push_back(sh_rd(a));
    @(negedge clk_i);
    req_i = 1'b1; w_en_i = w; addr_i = a; w_data_i = d; sel_byte_i = sel;
    got = 1'b0;
    lat = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk_i);
      lat++;
      if (ack_o) begin
        got = 1'b1;
        req_i = 1'b0;
        if (!w) chk({tag, "_rdata"}, r_data_o, rd_q.pop_front());
      end
    end
    req_i = 1'b0;
    chk({tag, "_ack"}, got, 1'b1);
    if (got) chk({tag, "_hit_latency1"}, lat == 1, !miss);
    if (!got && !w) void'(rd_q.pop_front());
    if (w) sh_wr(a, d, sel);
  endtask

  initial begin
    int rd0, wr0, fd;
    bit got, ack_after_done;

    repeat (2) @(negedge clk_i);
    chk("rst_ack", ack_o, 1'b0);
    chk("rst_flush_done", flush_done_o, 1'b0);
    chk("rst_mem_req", mem_req_o, 1'b0);
    chk("rst_mem_w_en", mem_w_en_o, 1'b0);
    chk("rst_r_data", r_data_o, 32'h0);
    chk("rst_mem_addr", mem_addr_o, 32'h0);
    chk("rst_mem_w_data", mem_w_data_o, {LB{1'b0}});
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Cold read, then a repeat hit with no memory traffic.
    access(0, 32'h0000_1004, 32'h0, 4'hF, 1, "cold_rd");
    rd0 = n_mem_rd;
    access(0, 32'h0000_1004, 32'h0, 4'hF, 0, "warm_rd");
    chk("warm_no_mem", n_mem_rd, rd0);

    // Partial-byte write hit and merged readback.
    access(1, 32'h0000_1004, 32'hDEAD_BEEF, 4'b0011, 0, "wr_half");
    access(0, 32'h0000_1004, 32'h0, 4'hF, 0, "rd_merged");
    chk("merged_value", sh_rd(32'h0000_1004), {pat(32'h0000_1004) >> 16, 16'hBEEF});

    // Two dirty lines in set 0; a third tag evicts the round-robin victim (way 0, 0x1000).
    access(1, 32'h0000_2000, 32'h1234_5678, 4'hF, 1, "wr_2000");
    push_wb(32'h0000_1000);
    access(0, 32'h0000_3000, 32'h0, 4'hF, 1, "rd_3000_evict");
    access(1, 32'h0000_3000, 32'hCAFE_F00D, 4'b1100, 0, "wr_3000");
    access(1, 32'h0000_1010, 32'h0BAD_F00D, 4'hF, 1, "wr_1010");

    // Flush with three dirty lines while a read is held on req_i.
    @(negedge clk_i);
    wr0 = n_mem_wr;
    push_wb(32'h0000_3000);
    push_wb(32'h0000_2000);
    push_wb(32'h0000_1010);
    exp_mem.push_back('{1'b0, 32'h0000_1010, {LB{1'b0}}});
    exp_misses++;
    rd_q.push_back(sh_rd(32'h0000_1010));
    dcache_flush_i = 1'b1;
    req_i = 1'b1; w_en_i = 1'b0; addr_i = 32'h0000_1010; sel_byte_i = 4'hF;
    fd = 0;
    got = 1'b0;
    ack_after_done = 1'b0;
    for (int i = 0; i < 2000 && !got; i++) begin
      @(negedge clk_i);
      dcache_flush_i = 1'b0;
      if (flush_done_o) fd++;
      if (ack_o) begin
        got = 1'b1;
        ack_after_done = (fd == 1);
        req_i = 1'b0;
        chk("held_rd_rdata", r_data_o, rd_q.pop_front());
      end
    end
    req_i = 1'b0;
    repeat (5) begin
      @(negedge clk_i);
      if (flush_done_o) fd++;
    end
    chk("held_rd_ack", got, 1'b1);
    chk("held_ack_after_flush", ack_after_done, 1'b1);
    chk("flush_done_pulses", fd, 1);
    chk("flush_wr_count", n_mem_wr - wr0, 3);
    access(0, 32'h0000_3000, 32'h0, 4'hF, 1, "post_flush_3000");
    access(0, 32'h0000_2000, 32'h0, 4'hF, 1, "post_flush_2000");

    // Reset while a refill is outstanding.
    exp_mem.push_back('{1'b0, 32'h0000_4000, {LB{1'b0}}});
    @(negedge clk_i);
    req_i = 1'b1; w_en_i = 1'b0; addr_i = 32'h0000_4000; sel_byte_i = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i);
      if (mem_req_o) got = 1'b1;
    end
    chk("alloc_started", got, 1'b1);
    #2 rst_ni = 1'b0;
    #1;
    chk("midrst_mem_req", mem_req_o, 1'b0);
    chk("midrst_ack", ack_o, 1'b0);
    chk("midrst_mem_addr", mem_addr_o, 32'h0);
    req_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    exp_hits = 0;
    exp_misses = 0;
    access(0, 32'h0000_4000, 32'h0, 4'hF, 1, "after_rst_rd");
    access(0, 32'h0000_4000, 32'h0, 4'hF, 0, "after_rst_hit1");
    access(0, 32'h0000_4008, 32'h0, 4'hF, 0, "after_rst_hit2");
`ifdef WB_DCACHE_PERF_CNT_EN
    chk("hit_cnt", hit_cnt_o, 32'(exp_hits));
    chk("miss_cnt", miss_cnt_o, 32'(exp_misses));
`endif
    repeat (5) @(negedge clk_i);
    chk("mem_queue_drained", exp_mem.size(), 0);
    chk("idle_mem_req", mem_req_o, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
